// File: rtl/snn_spike_classifier_pkg.sv
// Shared types and defaults for the spike classifier: FSM encoding,
// default window timing and the phase-counter width helper.
package snn_spike_classifier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_N_OUT  = 2;
  localparam int DEF_WINDOW = 15;
  localparam int DEF_GAP    = 1;
  localparam int DEF_CNT_W  = 8;

  // One counter times both the CLEAR gap and the RUN window.
  function automatic int phase_cnt_w(input int window, input int gap);
    return $clog2(((window > gap) ? window : gap) + 1);
  endfunction

endpackage

// File: rtl/snn_spike_classifier_spike_counter.sv
// Saturating per-neuron spike counter with sync clear and enable.
// Exposes the next-state count so the label can be registered on the last RUN edge.
module snn_spike_classifier_spike_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             spk_i,
  output logic [CNT_W-1:0] cnt_d_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                             cnt_d = '0;
    else if (en_i && spk_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/snn_spike_classifier.sv
// Runs one GAP+WINDOW inference window per accepted frame, counts output spikes
// per neuron and hands the argmax label plus raw counts downstream.
module snn_spike_classifier
  import snn_spike_classifier_pkg::*;
#(
  parameter int N_OUT  = DEF_N_OUT,
  parameter int WINDOW = DEF_WINDOW,
  parameter int GAP    = DEF_GAP,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LBL_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OUT-1:0]       spk_in,
  output logic                   net_reset,
  output logic                   label_valid,
  input  logic                   label_ready,
  output logic [LBL_W-1:0]       label,
  output logic [N_OUT*CNT_W-1:0] cnt_out
);

  localparam int PW = phase_cnt_w(WINDOW, GAP);

  state_e                        state_q, state_d;
  logic [PW-1:0]                 ph_q, ph_d;
  logic [N_OUT-1:0][CNT_W-1:0]   cnt_nxt;
  logic                          cnt_clr, cnt_en, load;
  logic [CNT_W-1:0]              best_cnt;
  logic [LBL_W-1:0]              best_idx;
  logic [LBL_W-1:0]              label_q;
  logic [N_OUT*CNT_W-1:0]        cnt_out_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid) state_d = ST_CLEAR;
      ST_CLEAR: if (ph_q == PW'(GAP - 1)) state_d = ST_RUN;
      ST_RUN:   if (ph_q == PW'(WINDOW - 1)) state_d = ST_DONE;
      ST_DONE:  if (label_ready) state_d = in_valid ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Phase counter restarts on every state change, so it only ever counts
  // within CLEAR or RUN.
  always_comb begin
    ph_d = '0;
    if (state_d == state_q && (state_q == ST_CLEAR || state_q == ST_RUN))
      ph_d = ph_q + 1'b1;
  end

  always_comb begin
    in_ready    = (state_q == ST_IDLE) || (state_q == ST_DONE && label_ready);
    net_reset   = (state_q != ST_RUN);
    label_valid = (state_q == ST_DONE);
    cnt_en      = (state_q == ST_RUN);
    cnt_clr     = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
    load        = (state_q == ST_RUN) && (state_d == ST_DONE);
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_cnt
    snn_spike_classifier_spike_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .spk_i   (spk_in[i]),
      .cnt_d_o (cnt_nxt[i])
    );
  end

  // Strict '>' keeps the lowest index on ties; all-zero counts give 0.
  always_comb begin
    best_cnt = cnt_nxt[0];
    best_idx = '0;
    for (int i = 1; i < N_OUT; i++) begin
      if (cnt_nxt[i] > best_cnt) begin
        best_cnt = cnt_nxt[i];
        best_idx = LBL_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      label_q   <= '0;
      cnt_out_q <= '0;
    end else if (load) begin
      label_q   <= best_idx;
      cnt_out_q <= cnt_nxt;
    end
  end

  assign label   = label_q;
  assign cnt_out = cnt_out_q;

endmodule

// File: tb/tb_snn_spike_classifier.sv
// Randomized bench for snn_spike_classifier: two DUTs (CNT_W=8 and CNT_W=3) share
// stimulus and are checked every cycle against a frame-age model plus literal pins.
module tb_snn_spike_classifier;
  import snn_spike_classifier_pkg::*;

  localparam int N = 2;
  localparam int W = DEF_WINDOW;
  localparam int G = DEF_GAP;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         label_ready = 1'b0;
  logic [N-1:0] spk_in = '0;

  logic         in_ready8, net_reset8, label_valid8;
  logic [0:0]   label8;
  logic [15:0]  cnt8;
  logic         in_ready3, net_reset3, label_valid3;
  logic [0:0]   label3;
  logic [5:0]   cnt3;

  snn_spike_classifier #(.N_OUT(N), .WINDOW(W), .GAP(G), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .spk_in(spk_in), .net_reset(net_reset8), .label_valid(label_valid8),
    .label_ready(label_ready), .label(label8), .cnt_out(cnt8)
  );

  snn_spike_classifier #(.N_OUT(N), .WINDOW(W), .GAP(G), .CNT_W(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
    .spk_in(spk_in), .net_reset(net_reset3), .label_valid(label_valid3),
    .label_ready(label_ready), .label(label3), .cnt_out(cnt3)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: age = edges since the frame was accepted (-1 when idle).
  int age = -1;
  int acc[N] = '{default: 0};
  int lc8[N] = '{default: 0};
  int lc3[N] = '{default: 0};
  int ll8 = 0, ll3 = 0;

  function automatic int sat(input int v, input int w);
    int m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic latch_result();
    int b8 = -1, b3 = -1;
    for (int i = 0; i < N; i++) begin
      lc8[i] = sat(acc[i], 8);
      lc3[i] = sat(acc[i], 3);
      if (lc8[i] > b8) begin b8 = lc8[i]; ll8 = i; end
      if (lc3[i] > b3) begin b3 = lc3[i]; ll3 = i; end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      age = -1;
      for (int i = 0; i < N; i++) begin acc[i] = 0; lc8[i] = 0; lc3[i] = 0; end
      ll8 = 0; ll3 = 0;
    end else begin
      bit idle, done, take;
      idle = (age < 0);
      done = (age == G + W);
      take = in_valid && (idle || (done && label_ready));
      if (!idle && !done) begin
        if (age >= G) for (int i = 0; i < N; i++) acc[i] += int'(spk_in[i]);
        age++;
        if (age == G + W) latch_result();
      end else if (done && label_ready) begin
        age = -1;
      end
      if (take) begin
        age = 0;
        for (int i = 0; i < N; i++) acc[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e8;
    logic [5:0]  e3;
    bit er, en, ev;
    er = (age < 0) || (age == G + W && label_ready);
    en = !(age >= G && age < G + W);
    ev = (age == G + W);
    for (int i = 0; i < N; i++) begin
      e8[i*8 +: 8] = 8'(lc8[i]);
      e3[i*3 +: 3] = 3'(lc3[i]);
    end
    chk("in_ready8", in_ready8, er);       chk("in_ready3", in_ready3, er);
    chk("net_reset8", net_reset8, en);     chk("net_reset3", net_reset3, en);
    chk("label_valid8", label_valid8, ev); chk("label_valid3", label_valid3, ev);
    chk("label8", label8, ll8);            chk("label3", label3, ll3);
    chk("cnt_out8", cnt8, e8);             chk("cnt_out3", cnt3, e3);
  end

  logic [1:0] sp[0:63];

  task automatic fill_sp(input logic [1:0] v);
    for (int k = 0; k < 64; k++) sp[k] = v;
  endtask

  task automatic start_frame();
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready8 && n < 50) begin @(posedge clk); #2; n++; end
    if (n >= 50) chk("in_ready_timeout", 0, 1);
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // Starts in the cycle right after the accepting edge; ends one edge into DONE.
  task automatic play(output int lat);
    bit seen = 0;
    lat = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      spk_in = sp[k];
      @(negedge clk);
      lat = k + 1;
      if (label_valid8) seen = 1;
      else begin @(posedge clk); #2; end
    end
    if (!seen) chk("label_valid_timeout", 0, 1);
    @(posedge clk); #2;
  endtask

  task automatic finish_frame(input int hold, input bit chain);
    repeat (hold) begin @(posedge clk); #2; end
    label_ready = 1'b1;
    if (chain) in_valid = 1'b1;
    @(posedge clk); #2;
    label_ready = 1'b0;
    in_valid    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit ch;
    #12;
    chk("rst_in_ready", in_ready8, 1);
    chk("rst_net_reset", net_reset8, 1);
    chk("rst_label_valid", label_valid8, 0);
    chk("rst_label", label8, 0);
    chk("rst_cnt_out", cnt8, 0);
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2;

    // Basic: neuron1 spikes every RUN cycle.
    fill_sp(2'b00);
    for (int k = G; k < G + W; k++) sp[k] = 2'b10;
    start_frame(); play(lat);
    chk("basic_latency", lat, 17);
    chk("basic_cnt8", cnt8, {8'd15, 8'd0});
    chk("basic_label8", label8, 1);
    chk("basic_cnt3", cnt3, {3'd7, 3'd0});
    finish_frame(0, 0);

    // Tie: 5 vs 5, lowest index wins.
    fill_sp(2'b00);
    for (int k = 1; k <= 5; k++) sp[k] = 2'b01;
    for (int k = 6; k <= 10; k++) sp[k] = 2'b10;
    start_frame(); play(lat);
    chk("tie_cnt8", cnt8, {8'd5, 8'd5});
    chk("tie_label8", label8, 0);
    finish_frame(1, 0);

    // Saturation: 15 vs 9 clips to 7 vs 7 at 3 bits.
    fill_sp(2'b00);
    for (int k = 1; k <= 15; k++) sp[k] = (k <= 9) ? 2'b11 : 2'b01;
    start_frame(); play(lat);
    chk("sat_cnt3", cnt3, {3'd7, 3'd7});
    chk("sat_label3", label3, 0);
    chk("sat_cnt8", cnt8, {8'd9, 8'd15});
    chk("sat_label8", label8, 0);
    finish_frame(0, 0);

    // Backpressure, then release with a new frame in the same cycle.
    fill_sp(2'b00);
    for (int k = 1; k <= 4; k++) sp[k] = 2'b11;
    sp[5] = 2'b10; sp[6] = 2'b10;
    start_frame(); play(lat);
    for (int h = 0; h < 10; h++) begin
      chk("bp_in_ready", in_ready8, 0);
      chk("bp_net_reset", net_reset8, 1);
      chk("bp_label", label8, 1);
      chk("bp_cnt", cnt8, {8'd6, 8'd4});
      @(posedge clk); #2;
    end
    in_valid = 1'b1; label_ready = 1'b1;
    #1 chk("bp_release_in_ready", in_ready8, 1);
    @(posedge clk); #2;
    in_valid = 1'b0; label_ready = 1'b0;
    chk("chain_clear_in_ready", in_ready8, 0);
    chk("chain_clear_net_reset", net_reset8, 1);
    chk("chain_clear_label_valid", label_valid8, 0);

    // Masking: the chained frame sees spikes only outside RUN.
    fill_sp(2'b11);
    for (int k = G; k < G + W; k++) sp[k] = 2'b00;
    play(lat);
    chk("mask_cnt8", cnt8, 0);
    chk("mask_label8", label8, 0);
    finish_frame(2, 0);

    // Reset in the middle of RUN.
    fill_sp(2'b11);
    start_frame();
    for (int k = 0; k < 8; k++) begin spk_in = sp[k]; @(posedge clk); #2; end
    #1 reset = 1'b0;
    #1;
    chk("midrst_net_reset", net_reset8, 1);
    chk("midrst_label_valid", label_valid8, 0);
    chk("midrst_in_ready", in_ready8, 1);
    spk_in = '0;
    @(posedge clk); #2;
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_in_ready", in_ready8, 1);

    // Random frames, random backpressure, random chaining.
    ch = 0;
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 64; k++) sp[k] = 2'($urandom_range(0, 3));
      if (!ch) start_frame();
      play(lat);
      chk("rand_latency", lat, 17);
      ch = (f < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      finish_frame(int'($urandom_range(0, 4)), ch);
    end

    repeat (3) begin @(posedge clk); #2; end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
